// File: rtl/ahb_cmd_sequencer.sv
// ahb_cmd_sequencer
// Command-side front end for the one_master_slave user interface. Write and
// read commands are queued in a small FIFO and replayed onto the master
// interface with fixed beat timing; read data comes back on a response port.
//
// Handshakes: a transfer happens on a rising hclk edge where both valid and
// ready are high. The producer holds cmd_* stable while cmd_valid=1 and
// cmd_ready=0. rsp_valid/rsp_data stay stable until rsp_ready is seen.
//
// Ports:
//   hclk, hresetn          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready    command handshake (cmd_ready = FIFO not full)
//   cmd_wr, cmd_sel        command kind (1 = write) and slave select
//   cmd_addr, cmd_dina/b   address and write operands
//   rsp_valid/rsp_ready    read response handshake, rsp_data = captured dout
//   enable, addr, wr,      registered master-side outputs
//   dina, dinb, slave_sel
//   dout                   read data from the master
//   busy                   FSM active or commands pending
//   fsm_state              debug view of the sequencer state
module ahb_cmd_sequencer #(
    parameter int DEPTH     = 4,
    parameter int READ_WAIT = 3
) (
    input  logic        hclk,
    input  logic        hresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_wr,
    input  logic [1:0]  cmd_sel,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_dina,
    input  logic [31:0] cmd_dinb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        enable,
    output logic [31:0] addr,
    output logic        wr,
    output logic [31:0] dina,
    output logic [31:0] dinb,
    output logic [1:0]  slave_sel,
    input  logic [31:0] dout,
    output logic        busy,
    output logic [2:0]  fsm_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ADDR  = 3'd1;
    localparam logic [2:0] S_WDATA = 3'd2;
    localparam logic [2:0] S_RWAIT = 3'd3;
    localparam logic [2:0] S_RSP   = 3'd4;

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int WW = (READ_WAIT > 1) ? $clog2(READ_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(READ_WAIT - 1);

    // FIFO entry layout: {wr, sel[1:0], addr[31:0], dina[31:0], dinb[31:0]}
    logic [98:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          push;
    logic          pop;
    logic [98:0]   head;

    logic [2:0]    state;
    logic [WW-1:0] wait_cnt;
    logic          cur_wr;
    logic [31:0]   cur_dina;
    logic [31:0]   cur_dinb;

    assign cmd_ready = (count != CW'(DEPTH));
    assign push      = cmd_valid && cmd_ready;
    // Pop decision uses the registered count, so a freshly pushed command
    // issues one edge later; there is no bypass path.
    assign pop       = (state == S_IDLE) && (count != '0);
    assign head      = mem[rd_ptr];
    assign busy      = (state != S_IDLE) || (count != '0);
    assign fsm_state = state;

    // Storage needs no reset: pointers and count define what is valid.
    always_ff @(posedge hclk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_wr, cmd_sel, cmd_addr, cmd_dina, cmd_dinb};
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            cur_wr    <= 1'b0;
            cur_dina  <= '0;
            cur_dinb  <= '0;
            enable    <= 1'b0;
            wr        <= 1'b0;
            slave_sel <= 2'b00;
            addr      <= '0;
            dina      <= '0;
            dinb      <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    enable    <= 1'b0;
                    slave_sel <= 2'b00;
                    wr        <= 1'b0;
                    if (pop) begin
                        addr      <= head[95:64];
                        slave_sel <= head[97:96];
                        enable    <= 1'b1;
                        cur_wr    <= head[98];
                        cur_dina  <= head[63:32];
                        cur_dinb  <= head[31:0];
                        state     <= S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (cur_wr) begin
                        dina  <= cur_dina;
                        dinb  <= cur_dinb;
                        wr    <= 1'b1;
                        state <= S_WDATA;
                    end else begin
                        wait_cnt <= '0;
                        state    <= S_RWAIT;
                    end
                end
                S_WDATA: begin
                    enable    <= 1'b0;
                    slave_sel <= 2'b00;
                    wr        <= 1'b0;
                    state     <= S_IDLE;
                end
                S_RWAIT: begin
                    // Enable stays high for the address cycle plus READ_WAIT
                    // wait cycles; dout is captured on the last one.
                    if (wait_cnt == WAIT_LAST) begin
                        rsp_data  <= dout;
                        rsp_valid <= 1'b1;
                        enable    <= 1'b0;
                        slave_sel <= 2'b00;
                        state     <= S_RSP;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_cmd_sequencer.sv
// Bench for ahb_cmd_sequencer. Commands are pushed by driver tasks; each
// accepted command queues its expected master transaction and, for reads,
// its expected response. Independent monitors pop and compare as the DUT
// presents enable pulses and response handshakes. The slave is modelled as
// dout = addr * 3.
module tb_ahb_cmd_sequencer;

    localparam int DEPTH     = 4;
    localparam int READ_WAIT = 3;

    logic        hclk;
    logic        hresetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_wr;
    logic [1:0]  cmd_sel;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_dina;
    logic [31:0] cmd_dinb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        enable;
    logic [31:0] addr;
    logic        wr;
    logic [31:0] dina;
    logic [31:0] dinb;
    logic [1:0]  slave_sel;
    logic [31:0] dout;
    logic        busy;
    logic [2:0]  fsm_state;

    ahb_cmd_sequencer #(.DEPTH(DEPTH), .READ_WAIT(READ_WAIT)) dut (
        .hclk(hclk), .hresetn(hresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_sel(cmd_sel), .cmd_addr(cmd_addr), .cmd_dina(cmd_dina),
        .cmd_dinb(cmd_dinb), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .enable(enable), .addr(addr), .wr(wr),
        .dina(dina), .dinb(dinb), .slave_sel(slave_sel), .dout(dout),
        .busy(busy), .fsm_state(fsm_state)
    );

    assign dout = addr * 32'd3;

    // ---------------- clock ----------------
    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [98:0] exp_q[$];   // {wr, sel, addr, dina, dinb}
    logic [31:0] rsp_q[$];
    int rsp_mode = 0;        // 0 always ready, 1 never ready, 2 random

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- drivers (called just after a rising edge) ----------------
    task automatic push_cmd(input logic w, input logic [1:0] s, input logic [31:0] a,
                            input logic [31:0] da, input logic [31:0] db);
        int waited = 0;
        bit ok = 0;
        cmd_valid = 1'b1;
        cmd_wr    = w;
        cmd_sel   = s;
        cmd_addr  = a;
        cmd_dina  = da;
        cmd_dinb  = db;
        while (!ok && waited < 200) begin
            @(negedge hclk);
            if (cmd_ready) ok = 1;
            @(posedge hclk);
            waited++;
        end
        check("push_accept", 1'(ok), 1'b1);
        if (ok) begin
            exp_q.push_back({w, s, a, da, db});
            if (!w) rsp_q.push_back(a * 32'd3);
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge hclk);
        #1;
    endtask

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge hclk);
            #1;
            case (rsp_mode)
                0:       rsp_ready = 1'b1;
                1:       rsp_ready = 1'b0;
                default: rsp_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // ---------------- master-side monitor ----------------
    logic        m_prev_en = 1'b0;
    bit          m_in_txn = 0;
    int          m_len = 0;
    logic [98:0] m_cur;

    initial begin
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                m_prev_en = 1'b0;
                m_in_txn  = 0;
            end else begin
                if (enable && !m_prev_en) begin
                    check("issue_while_rsp_valid", rsp_valid, 1'b0);
                    if (exp_q.size() == 0) begin
                        check("unexpected_issue", 1'b1, 1'b0);
                    end else begin
                        m_cur    = exp_q.pop_front();
                        m_in_txn = 1;
                        m_len    = 1;
                        check("issue_addr", addr, m_cur[95:64]);
                        check("issue_sel", slave_sel, m_cur[97:96]);
                        check("issue_wr_first", wr, 1'b0);
                    end
                end else if (enable && m_prev_en) begin
                    m_len++;
                    if (m_in_txn) begin
                        check("addr_held", addr, m_cur[95:64]);
                        check("sel_held", slave_sel, m_cur[97:96]);
                        if (m_cur[98] && m_len == 2) begin
                            check("write_wr", wr, 1'b1);
                            check("write_dina", dina, m_cur[63:32]);
                            check("write_dinb", dinb, m_cur[31:0]);
                        end else if (!m_cur[98]) begin
                            check("read_wr", wr, 1'b0);
                        end
                    end
                end else if (!enable && m_prev_en && m_in_txn) begin
                    check("enable_len", m_len, m_cur[98] ? 2 : 1 + READ_WAIT);
                    check("sel_cleared", slave_sel, 2'b00);
                    check("wr_cleared", wr, 1'b0);
                    m_in_txn = 0;
                end
                m_prev_en = enable;
            end
        end
    end

    // ---------------- response monitor ----------------
    logic        r_pv = 1'b0;
    logic        r_pr = 1'b0;
    logic [31:0] r_pd = '0;

    initial begin
        forever begin
            @(negedge hclk);
            if (!hresetn) begin
                r_pv = 1'b0;
            end else begin
                if (r_pv && !r_pr) begin
                    check("rsp_valid_hold", rsp_valid, 1'b1);
                    check("rsp_data_hold", rsp_data, r_pd);
                end
                if (rsp_valid && rsp_ready) begin
                    if (rsp_q.size() == 0) check("unexpected_rsp", 1'b1, 1'b0);
                    else check("rsp_data", rsp_data, rsp_q.pop_front());
                end
                r_pv = rsp_valid;
                r_pr = rsp_ready;
                r_pd = rsp_data;
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int en_cnt;
        int rsp_cnt;
        int waited;
        logic [5:0] pat;
        logic [31:0] a4;

        hresetn   = 1'b0;
        cmd_valid = 1'b0;
        cmd_wr    = 1'b0;
        cmd_sel   = 2'b00;
        cmd_addr  = '0;
        cmd_dina  = '0;
        cmd_dinb  = '0;
        repeat (3) @(posedge hclk);
        #1;
        check("reset_enable", enable, 1'b0);
        check("reset_outputs", {addr, dina, dinb, wr, slave_sel}, '0);
        check("reset_rsp", {rsp_valid, rsp_data}, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_cmd_ready", cmd_ready, 1'b1);
        hresetn = 1'b1;
        idle(2);

        // single write: enable high 2 cycles, no response
        rsp_mode = 0;
        push_cmd(1'b1, 2'b01, 32'd1, 32'd1, 32'd2);
        en_cnt = 0; rsp_cnt = 0;
        repeat (8) begin
            @(negedge hclk);
            en_cnt += int'(enable);
            rsp_cnt += int'(rsp_valid);
        end
        check("write_enable_cycles", en_cnt, 2);
        check("write_no_rsp", rsp_cnt, 0);
        idle(1);

        // single read: enable high 4 cycles, one response pulse of 3
        push_cmd(1'b0, 2'b01, 32'd1, 32'd0, 32'd0);
        en_cnt = 0; rsp_cnt = 0;
        repeat (12) begin
            @(negedge hclk);
            en_cnt += int'(enable);
            rsp_cnt += int'(rsp_valid);
        end
        check("read_enable_cycles", en_cnt, 1 + READ_WAIT);
        check("read_rsp_cycles", rsp_cnt, 1);
        idle(1);

        // read stalled in RSP with a write queued behind it
        rsp_mode = 1;
        push_cmd(1'b0, 2'b10, 32'd5, 32'd0, 32'd0);
        push_cmd(1'b1, 2'b11, 32'd6, 32'hAAAA_0001, 32'hBBBB_0002);
        idle(10);
        check("stall_rsp_valid", rsp_valid, 1'b1);
        check("stall_rsp_data", rsp_data, 32'd15);
        check("stall_write_held", enable, 1'b0);
        check("stall_busy", busy, 1'b1);
        rsp_mode = 0;
        idle(10);

        // FIFO fill: 4 accepts while stalled, 5th waits for a free slot
        rsp_mode = 1;
        push_cmd(1'b0, 2'b01, 32'h20, 32'd0, 32'd0);
        idle(2);
        for (int i = 0; i < 4; i++) push_cmd(1'b1, 2'b01, 32'(10 + i), $urandom, $urandom);
        check("full_cmd_ready", cmd_ready, 1'b0);
        rsp_mode = 0;
        push_cmd(1'b1, 2'b01, 32'd14, $urandom, $urandom);
        idle(25);
        check("fill_drained", exp_q.size(), 0);

        // reset during the read wait phase
        push_cmd(1'b0, 2'b10, 32'h40, 32'd0, 32'd0);
        waited = 0;
        while (!enable && waited < 20) begin
            @(posedge hclk); #1; waited++;
        end
        check("abort_read_issued", enable, 1'b1);
        @(posedge hclk);
        #3;
        hresetn = 1'b0;
        #1;
        check("abort_enable", enable, 1'b0);
        check("abort_outputs", {addr, dina, dinb, wr, slave_sel}, '0);
        check("abort_rsp", {rsp_valid, rsp_data}, '0);
        check("abort_busy", busy, 1'b0);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        exp_q.delete();
        rsp_q.delete();
        @(posedge hclk);
        @(posedge hclk);
        #1;
        hresetn = 1'b1;
        idle(2);
        push_cmd(1'b1, 2'b01, 32'h44, 32'h1234, 32'h5678);
        idle(6);

        // two writes back to back: enable 1,1,0,1,1,0
        push_cmd(1'b1, 2'b01, 32'h100, $urandom, $urandom);
        push_cmd(1'b1, 2'b10, 32'h104, $urandom, $urandom);
        pat = '0;
        a4 = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge hclk);
            pat[5 - i] = enable;
            if (i == 3) a4 = addr;
        end
        check("b2b_enable_pattern", pat, 6'b110110);
        check("b2b_second_addr", a4, 32'h104);
        idle(2);

        // randomized traffic with random response back-pressure
        rsp_mode = 2;
        for (int i = 0; i < 60; i++) begin
            idle($urandom_range(0, 3));
            push_cmd(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom);
        end
        rsp_mode = 0;
        waited = 0;
        while ((busy || rsp_valid) && waited < 1000) begin
            @(posedge hclk); #1; waited++;
        end
        check("drain_done", busy, 1'b0);
        idle(3);
        check("exp_q_empty", exp_q.size(), 0);
        check("rsp_q_empty", rsp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ahb_cmd_sequencer.md
Name: ahb_cmd_sequencer

Overview:
- Command-side front end that drives the user interface of one_master_slave: enable, addr, wr, dina, dinb, slave_sel, with dout read back.
- Accepts write and read commands through a valid/ready port into a small command FIFO.
- Plays each command onto the master interface with the fixed write and read beat timing.
- Returns read data through a valid/ready response port.

Parameters:
- DEPTH, 4: command FIFO entries; power of 2, at least 2.
- READ_WAIT, 3: cycles enable is held after the read address cycle before dout is sampled.

Ports:
- hclk  in  1  system clock, rising edge.
- hresetn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  FIFO can accept; equals !full.
- cmd_wr  in  1  1 = write, 0 = read.
- cmd_sel  in  2  slave_sel value for this command.
- cmd_addr  in  32  target address.
- cmd_dina  in  32  write operand A; ignored for reads.
- cmd_dinb  in  32  write operand B; ignored for reads.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_data  out  32  captured dout.
- enable  out  1  to master.
- addr  out  32  to master.
- wr  out  1  to master.
- dina  out  32  to master.
- dinb  out  32  to master.
- slave_sel  out  2  to master.
- dout  in  32  from master.
- busy  out  1  FSM not IDLE, or FIFO non-empty.

Behaviour:
- Reset (asynchronous, hresetn=0):
  - FIFO flushed; FSM to IDLE.
  - enable, wr, slave_sel, rsp_valid = 0.
  - addr, dina, dinb, rsp_data = 0.
  - Reset mid-transaction aborts it immediately; no response is produced.
- All master-side outputs are registered.
- FIFO:
  - Push when cmd_valid & cmd_ready.
  - Pop only from IDLE when count != 0, using the registered count. A command pushed into an empty FIFO is popped on the following edge; there is no same-cycle bypass.
  - Push and pop on the same edge leave count unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE, ADDR, WDATA, RWAIT, RSP.
- IDLE:
  - enable=0, slave_sel=0, wr=0; addr, dina and dinb hold their last values.
  - If FIFO non-empty: on that edge pop the entry, set addr=cmd_addr, slave_sel=cmd_sel, enable=1, wr=0, then go to ADDR.
- ADDR:
  - Write: on the next edge set dina, dinb, wr=1 (enable and slave_sel held), then go to WDATA.
  - Read: wr stays 0; clear wait counter; go to RWAIT.
- WDATA: on the next edge set enable=0, slave_sel=0, wr=0; go to IDLE. Enable is high exactly 2 cycles per write.
- RWAIT:
  - Counter increments each edge.
  - On the edge where counter == READ_WAIT-1: rsp_data <= dout, enable=0, slave_sel=0, rsp_valid=1; go to RSP.
  - Enable is high exactly 1+READ_WAIT cycles per read (4 at default).
- RSP:
  - rsp_valid and rsp_data are held stable until rsp_ready.
  - On an edge with rsp_ready=1: rsp_valid=0; go to IDLE.
  - The FIFO may keep accepting commands, but no command issues while in RSP (stall).
- Spacing: at least one enable-low cycle between consecutive commands, because IDLE always lasts at least 1 cycle.
- Write throughput: at most 1 write per 3 cycles.
- cmd_sel=2'b00 is issued unchanged; the block does not validate it.
- cmd_ready=0 while full; cmd_valid while full is held off with no data loss (the producer must hold the command).
- rsp_ready asserted outside RSP is ignored.

Test Plan:
- Reset, then push write (addr=1, sel=01, dina=1, dinb=2) -> next edge enable=1, addr=1, slave_sel=01, wr=0; following edge dina=1, dinb=2, wr=1; following edge enable=0, wr=0, slave_sel=0; rsp_valid never asserts.
- Push read (addr=1, sel=01) with dout forced to 32'h0000_0003, rsp_ready=1 -> enable high exactly 4 cycles with wr=0; rsp_valid pulses 1 cycle with rsp_data=3.
- Read with rsp_ready=0 for 5 cycles, plus a write queued behind it -> rsp_valid and rsp_data held; write's enable does not rise until the cycle after rsp_ready=1.
- Push 5 commands back-to-back with DEPTH=4 while the FSM is busy -> cmd_ready drops after the 4th accept; the 5th is accepted once the first pop frees a slot; all 5 issue in order (check addr sequence 10,11,12,13,14).
- Assert hresetn=0 during RWAIT of a read -> all outputs 0 asynchronously, busy=0, FIFO empty; after release a new write issues normally.
- Two writes pushed on consecutive cycles -> enable pattern 1,1,0,1,1,0 with the second addr appearing on the 4th cycle.
